// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request/grant bus between the requesters and the register-file write arbiter.
// The requester side uses the master modport and the arbiter uses the slave modport.
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16,
    parameter int GID_W   = $clog2(NUM_REQ)
);
    logic                      stall;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_reg;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [ADDR_W-1:0]         write_reg;
    logic [DATA_W-1:0]         data;
    logic                      reg_write_flag;
    logic [GID_W-1:0]          grant_id;
    logic [CNT_W-1:0]          wr_count;

    modport master (
        output stall, req_valid, req_reg, req_data,
        input  req_ready, write_reg, data, reg_write_flag, grant_id, wr_count
    );

    modport slave (
        input  stall, req_valid, req_reg, req_data,
        output req_ready, write_reg, data, reg_write_flag, grant_id, wr_count
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares the register file's single write port among NUM_REQ
// writeback requesters. The write port outputs are registered, giving one write per cycle.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int GID_W = $clog2(NUM_REQ);

    logic [GID_W-1:0]   ptr;
    logic [GID_W-1:0]   win;
    logic               found;
    logic [NUM_REQ-1:0] ready_c;
    logic               accept;
    logic [ADDR_W-1:0]  win_reg;
    logic [DATA_W-1:0]  win_data;
    int                 idx;

    // Search upward from the pointer, wrapping, for the first valid requester.
    always_comb begin
        idx     = 0;
        win     = '0;
        found   = 1'b0;
        ready_c = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = GID_W'(idx);
            end
        end
        if (found && !bus.stall && !rst) ready_c[win] = 1'b1;
    end

    assign bus.req_ready = ready_c;
    assign accept        = |ready_c;
    assign win_reg       = bus.req_reg[win*ADDR_W +: ADDR_W];
    assign win_data      = bus.req_data[win*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr                <= '0;
            bus.reg_write_flag <= 1'b0;
            bus.write_reg      <= '0;
            bus.data           <= '0;
            bus.grant_id       <= '0;
            bus.wr_count       <= '0;
        end else begin
            bus.reg_write_flag <= 1'b0;
            if (accept) begin
                bus.write_reg      <= win_reg;
                bus.data           <= win_data;
                bus.grant_id       <= win;
                // $zero writes complete the handshake but never reach the regfile.
                bus.reg_write_flag <= (win_reg != '0);
                if (win_reg != '0) bus.wr_count <= bus.wr_count + CNT_W'(1);
                ptr <= (win == GID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            end
        end
    end
endmodule
